// File: rtl/aes_block_buffer_if.sv
// aes_block_buffer_if
// Bundles every non-clock, non-reset signal of aes_block_buffer.
//   slave  : the buffer itself (FIFO/core inputs in, read/start/write/error out)
//   master : the environment around it (input FIFO, AES core, output FIFO)
// Signal groups:
//   parameter load : iParam_load, iWords, iEnable
//   input FIFO     : iFF_in_empty, oFF_in_read_req, iFF_in_data
//   AES core       : oStart, oBlock, iCore_busy, iCore_valid, iCore_block
//   output FIFO    : iFF_out_almost_full, oFF_out_write_req, oFF_out_data
//   status         : oErr
interface aes_block_buffer_if #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 8,
    parameter int CW        = $clog2(MAX_WORDS) + 1
);
    logic                        iParam_load;
    logic [CW-1:0]               iWords;
    logic                        iEnable;
    logic                        iFF_in_empty;
    logic                        oFF_in_read_req;
    logic [DATA_W-1:0]           iFF_in_data;
    logic                        oStart;
    logic [MAX_WORDS*DATA_W-1:0] oBlock;
    logic                        iCore_busy;
    logic                        iCore_valid;
    logic [MAX_WORDS*DATA_W-1:0] iCore_block;
    logic                        iFF_out_almost_full;
    logic                        oFF_out_write_req;
    logic [DATA_W-1:0]           oFF_out_data;
    logic                        oErr;

    modport slave (
        input  iParam_load, iWords, iEnable,
        input  iFF_in_empty, iFF_in_data,
        output oFF_in_read_req,
        output oStart, oBlock,
        input  iCore_busy, iCore_valid, iCore_block,
        input  iFF_out_almost_full,
        output oFF_out_write_req, oFF_out_data,
        output oErr
    );

    modport master (
        output iParam_load, iWords, iEnable,
        output iFF_in_empty, iFF_in_data,
        input  oFF_in_read_req,
        input  oStart, oBlock,
        output iCore_busy, iCore_valid, iCore_block,
        output iFF_out_almost_full,
        input  oFF_out_write_req, oFF_out_data,
        input  oErr
    );
endinterface

// File: rtl/aes_block_buffer.sv
// aes_block_buffer
// Collects W words from the input FIFO into one AES block, hands the block to
// the core with a one-cycle oStart, and streams each core result word by word
// into the output FIFO through two ping-pong result slots.
// Ports:
//   iClk : clock, all state on its rising edge
//   iRst : asynchronous active-high reset
//   bus  : aes_block_buffer_if.slave (parameter load, input FIFO, core, output FIFO, oErr)
module aes_block_buffer #(
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 8
) (
    input  logic              iClk,
    input  logic              iRst,
    aes_block_buffer_if.slave bus
);
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int IW = $clog2(MAX_WORDS);
    localparam logic [CW-1:0] MAX_W = CW'(MAX_WORDS);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} fill_state_t;

    // input side
    fill_state_t   state_reg;
    logic [CW-1:0] w_reg;
    logic [CW-1:0] issued_reg;
    logic [CW-1:0] captured_reg;
    logic          rd_pending_reg;

    // output side
    logic [1:0]        reserved_reg;
    logic [1:0]        inflight_reg;
    logic [1:0]        slot_occ_reg;
    logic [CW-1:0]     slot_words_reg [2];
    logic [DATA_W-1:0] slot_data_reg  [2][MAX_WORDS];
    logic              head_reg;
    logic              wr_ptr_reg;
    logic              res_ptr_reg;
    logic [CW-1:0]     rd_idx_reg;
    logic              out_wr_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              err_reg;

    logic bad_words;
    logic read_req;
    logic start;
    logic capture;
    logic last_capture;
    logic core_accept;
    logic drain_go;
    logic drain_done;

    assign bad_words = (bus.iWords == '0) || (bus.iWords > MAX_W);

    // read_req and start are combinational outputs; gating with iRst keeps
    // them low for the whole time reset is held.
    assign read_req = ~iRst & (state_reg == FILL) & ~bus.iFF_in_empty & bus.iEnable
                    & (issued_reg < w_reg) & ~bus.iParam_load;
    assign start    = ~iRst & (state_reg == HOLD) & ~bus.iCore_busy
                    & (reserved_reg < 2'd2) & ~bus.iParam_load;

    // A parameter load in the data-return cycle discards that word.
    assign capture      = rd_pending_reg & ~bus.iParam_load;
    assign last_capture = capture & ((captured_reg + CW'(1)) == w_reg);

    // A result with nothing in flight is dropped (and flagged).
    assign core_accept = bus.iCore_valid & (inflight_reg != 2'd0);

    assign drain_go   = slot_occ_reg[head_reg] & ~bus.iFF_out_almost_full;
    assign drain_done = drain_go & (rd_idx_reg == (slot_words_reg[head_reg] - CW'(1)));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg      <= FILL;
            w_reg          <= MAX_W;
            issued_reg     <= '0;
            captured_reg   <= '0;
            rd_pending_reg <= 1'b0;
        end else begin
            rd_pending_reg <= read_req;
            if (bus.iParam_load) begin
                w_reg        <= bad_words ? MAX_W : bus.iWords;
                issued_reg   <= '0;
                captured_reg <= '0;
                state_reg    <= FILL;
            end else begin
                case (state_reg)
                    FILL: begin
                        if (read_req)
                            issued_reg <= issued_reg + CW'(1);
                        if (capture) begin
                            captured_reg <= captured_reg + CW'(1);
                            if (last_capture)
                                state_reg <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (start) begin
                            issued_reg   <= '0;
                            captured_reg <= '0;
                            state_reg    <= FILL;
                        end
                    end
                    default: state_reg <= FILL;
                endcase
            end
        end
    end

    // Block assembly registers; words beyond the current W read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_WORDS; gi++) begin : g_in_word
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst)
                    word_reg <= '0;
                else if (capture && (captured_reg[IW-1:0] == IW'(gi)))
                    word_reg <= bus.iFF_in_data;
            end
            assign bus.oBlock[gi*DATA_W +: DATA_W] = (CW'(gi) < w_reg) ? word_reg : '0;
        end
    endgenerate

    // Slots are used strictly in rotation: res_ptr assigns a slot (and its
    // word count) at start, wr_ptr fills it on the result, head drains it.
    // With at most two reservations the written slot is never the one draining.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            reserved_reg <= 2'd0;
            inflight_reg <= 2'd0;
            slot_occ_reg <= 2'b00;
            head_reg     <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            res_ptr_reg  <= 1'b0;
            rd_idx_reg   <= '0;
            out_wr_reg   <= 1'b0;
            out_data_reg <= '0;
            err_reg      <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                slot_words_reg[s] <= MAX_W;
                for (int k = 0; k < MAX_WORDS; k++)
                    slot_data_reg[s][k] <= '0;
            end
        end else begin
            if (start) begin
                slot_words_reg[res_ptr_reg] <= w_reg;
                res_ptr_reg                 <= ~res_ptr_reg;
            end

            if (core_accept) begin
                for (int k = 0; k < MAX_WORDS; k++)
                    slot_data_reg[wr_ptr_reg][k] <= bus.iCore_block[k*DATA_W +: DATA_W];
                slot_occ_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end

            out_wr_reg <= drain_go;
            if (drain_go) begin
                out_data_reg <= slot_data_reg[head_reg][rd_idx_reg[IW-1:0]];
                if (drain_done) begin
                    slot_occ_reg[head_reg] <= 1'b0;
                    head_reg               <= ~head_reg;
                    rd_idx_reg             <= '0;
                end else begin
                    rd_idx_reg <= rd_idx_reg + CW'(1);
                end
            end

            case ({start, drain_done})
                2'b10:   reserved_reg <= reserved_reg + 2'd1;
                2'b01:   reserved_reg <= reserved_reg - 2'd1;
                default: reserved_reg <= reserved_reg;
            endcase

            case ({start, core_accept})
                2'b10:   inflight_reg <= inflight_reg + 2'd1;
                2'b01:   inflight_reg <= inflight_reg - 2'd1;
                default: inflight_reg <= inflight_reg;
            endcase

            if ((bus.iParam_load && bad_words) || (bus.iCore_valid && !core_accept))
                err_reg <= 1'b1;
        end
    end

    assign bus.oFF_in_read_req   = read_req;
    assign bus.oStart            = start;
    assign bus.oFF_out_write_req = out_wr_reg;
    assign bus.oFF_out_data      = out_data_reg;
    assign bus.oErr              = err_reg;
endmodule
